// File: rtl/cla16_adder.sv
// rtl/cla16_adder.sv - 16-bit two-level carry-lookahead adder with registered 17-bit sum
// Four 4-bit lookahead slices share a second-level carry unit; no ripple path between slices.
module cla16_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        c,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        c16,
    output logic [16:0] finResult
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] sum;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  slice_c;
    logic        unused_c16;

    // c16 is a reserved pin; it is deliberately kept out of the datapath.
    assign unused_c16 = c16;

    assign g = x & y;
    assign p = x ^ y;

    for (genvar k = 0; k < 4; k++) begin : g_slice
        logic [3:0] gs;
        logic [3:0] ps;
        logic [3:0] cs;
        logic       cin;

        assign gs  = g[4*k +: 4];
        assign ps  = p[4*k +: 4];
        assign cin = slice_c[k];

        assign cs[0] = cin;
        assign cs[1] = gs[0] | (ps[0] & cin);
        assign cs[2] = gs[1] | (ps[1] & gs[0]) | (ps[1] & ps[0] & cin);
        assign cs[3] = gs[2] | (ps[2] & gs[1]) | (ps[2] & ps[1] & gs[0])
                     | (ps[2] & ps[1] & ps[0] & cin);

        assign gg[k] = gs[3] | (ps[3] & gs[2]) | (ps[3] & ps[2] & gs[1])
                     | (ps[3] & ps[2] & ps[1] & gs[0]);
        assign gp[k] = &ps;

        assign sum[4*k +: 4] = ps ^ cs;
    end

    // Second-level lookahead: every slice carry-in is a flat sum of products of GG/GP and c.
    assign slice_c[0] = c;
    assign slice_c[1] = gg[0] | (gp[0] & c);
    assign slice_c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c);
    assign slice_c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                      | (gp[2] & gp[1] & gp[0] & c);
    assign slice_c[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                      | (gp[3] & gp[2] & gp[1] & gg[0])
                      | (gp[3] & gp[2] & gp[1] & gp[0] & c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            finResult <= 17'h00000;
        end else begin
            finResult <= {slice_c[4], sum};
        end
    end

endmodule

// File: tb/tb_cla16_adder.sv
// tb/tb_cla16_adder.sv - self-checking bench for cla16_adder
module tb_cla16_adder;

    logic        clk;
    logic        rst;
    logic        c;
    logic [15:0] x;
    logic [15:0] y;
    logic        c16;
    logic [16:0] finResult;

    int checks;
    int failures;

    cla16_adder top (
        .clk       (clk),
        .rst       (rst),
        .c         (c),
        .x         (x),
        .y         (y),
        .c16       (c16),
        .finResult (finResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic ci);
        return 17'(a) + 17'(b) + 17'(ci);
    endfunction

    task automatic check(input string tag, input logic [16:0] exp);
        checks++;
        assert (finResult === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, finResult, exp);
        end
    endtask

    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic [16:0] exp, input string tag);
        @(negedge clk);
        x = a;
        y = b;
        c = ci;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        logic [16:0] exp_q[$];
        logic [4:0]  c16_vals;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        c   = 1'b0;
        x   = 16'h1234;
        y   = 16'h1111;
        c16 = 1'b0;

        #2;
        check("reset_async", 17'h00000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 17'h00000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release", 17'h02345);

        apply(16'd15, 16'd2,  1'b0, 17'd17, "small_15_2");
        apply(16'd1,  16'd1,  1'b0, 17'd2,  "small_1_1");
        apply(16'd3,  16'd3,  1'b0, 17'd6,  "small_3_3");
        apply(16'd8,  16'd8,  1'b0, 17'd16, "small_8_8");
        apply(16'd15, 16'd15, 1'b0, 17'd30, "small_15_15");
        apply(16'd31, 16'd31, 1'b0, 17'd62, "small_31_31");

        apply(16'd12901, 16'd1224,  1'b0, 17'd14125, "slice_12901_1224");
        apply(16'd32768, 16'd12240, 1'b0, 17'd45008, "slice_32768_12240");
        apply(16'd400,   16'd66,    1'b0, 17'd466,   "slice_400_66");

        apply(16'd600,   16'hFFFF, 1'b0, 17'h10257, "ovf_600_ffff");
        apply(16'hFFFF,  16'h0000, 1'b1, 17'h10000, "ovf_ffff_cin");
        apply(16'h0F0F,  16'hF0F0, 1'b1, 17'h10000, "propagate_cin1");
        apply(16'h0F0F,  16'hF0F0, 1'b0, 17'h0FFFF, "propagate_cin0");

        // Mid-cycle input change must not disturb the held result.
        #2;
        x = 16'h0001;
        y = 16'h0001;
        #1;
        check("hold_between_edges", 17'h0FFFF);

        // Reset asserted mid-stream clears immediately and discards the pending sum.
        apply(16'd600, 16'hFFFF, 1'b0, 17'h10257, "pre_midreset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_async", 17'h00000);
        @(posedge clk);
        #1;
        check("midreset_hold", 17'h00000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_release", 17'h10257);

        c16_vals = 5'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            case (i)
                0: c16 = 1'b0;
                1: c16 = 1'b1;
                2: c16 = 1'bx;
                default: c16 = 1'bz;
            endcase
            x = 16'd600;
            y = 16'hFFFF;
            c = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("c16_indep_%0d", i), 17'h10257);
        end
        c16 = 1'b0;

        // Back-to-back random vectors, one per cycle, checked one edge later.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            x = 16'($urandom);
            y = 16'($urandom);
            c = 1'($urandom);
            exp_q.push_back(ref_sum(x, y, c));
            @(posedge clk);
            #1;
            check($sformatf("random_%0d", i), exp_q.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
